// File: rtl/board_store.sv
// board_store: authoritative 3x3 tic-tac-toe board.
//
// Move requests and timeout auto-moves are serialised through a small FSM
// (IDLE, CHECK, SCAN, WRITE, EVAL). Acceptance/rejection pulses and the
// full/winner flags are registered.
//
// Ports:
//   clk          system clock
//   Reset        synchronous active-high reset
//   clear        new-game pulse, empties the board from any state
//   move_req     place a mark at posicion (sampled only in IDLE)
//   posicion     target cell 0..8, row = posicion/3, col = posicion%3
//   jug          player making the move (0 -> CELL_P1, 1 -> CELL_P2)
//   timeout      auto-place jug's mark in the lowest-index empty cell
//   matriz_juego board, indexed [row][col]
//   move_ack     one-cycle pulse, move committed
//   move_err     one-cycle pulse, move rejected
//   busy         high outside IDLE
//   lleno        all nine cells occupied
//   ganador      a three-in-a-row exists
//   ganador_jug  cell code of the winning line (CELL_EMPTY if none)
//   last_pos     last committed cell, 4'hF when none
`timescale 1ns / 1ps

module board_store #(
  parameter logic [1:0] CELL_EMPTY = 2'b00,
  parameter logic [1:0] CELL_P1    = 2'b01,
  parameter logic [1:0] CELL_P2    = 2'b10
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  clear,
  input  logic                  move_req,
  input  logic [3:0]            posicion,
  input  logic                  jug,
  input  logic                  timeout,
  output logic [2:0][2:0][1:0]  matriz_juego,
  output logic                  move_ack,
  output logic                  move_err,
  output logic                  busy,
  output logic                  lleno,
  output logic                  ganador,
  output logic [1:0]            ganador_jug,
  output logic [3:0]            last_pos
);

  typedef enum logic [2:0] {StIdle, StCheck, StScan, StWrite, StEval} state_e;

  state_e            state_q, state_d;
  logic [8:0][1:0]   board_q, board_d;
  logic [3:0]        pos_q, pos_d;
  logic [3:0]        scan_q, scan_d;
  logic [3:0]        last_pos_q, last_pos_d;
  logic              jug_q, jug_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              lleno_q, lleno_d;
  logic              gan_q, gan_d;
  logic [1:0]        gjug_q, gjug_d;

  logic [1:0]        target_cell;
  logic [1:0]        scan_cell;
  logic [1:0]        mark;
  logic [7:0][1:0]   line_codes;
  logic [1:0]        win_code;
  logic              full;

  // Code of a line if all three cells match, else CELL_EMPTY. An all-empty
  // line naturally yields CELL_EMPTY.
  function automatic logic [1:0] line_code(input logic [1:0] a, input logic [1:0] b,
                                           input logic [1:0] c);
    return ((a == b) && (b == c)) ? a : CELL_EMPTY;
  endfunction

  assign mark = jug_q ? CELL_P2 : CELL_P1;

  // Cell lookups with indices that may exceed 8; out-of-range reads as empty
  // but the CHECK state rejects those positions first.
  always_comb begin
    target_cell = CELL_EMPTY;
    scan_cell   = CELL_EMPTY;
    for (int i = 0; i < 9; i++) begin
      if (pos_q == 4'(i))  target_cell = board_q[i];
      if (scan_q == 4'(i)) scan_cell   = board_q[i];
    end
  end

  // Line and fullness evaluation on the committed board.
  always_comb begin
    line_codes[0] = line_code(board_q[0], board_q[1], board_q[2]);
    line_codes[1] = line_code(board_q[3], board_q[4], board_q[5]);
    line_codes[2] = line_code(board_q[6], board_q[7], board_q[8]);
    line_codes[3] = line_code(board_q[0], board_q[3], board_q[6]);
    line_codes[4] = line_code(board_q[1], board_q[4], board_q[7]);
    line_codes[5] = line_code(board_q[2], board_q[5], board_q[8]);
    line_codes[6] = line_code(board_q[0], board_q[4], board_q[8]);
    line_codes[7] = line_code(board_q[2], board_q[4], board_q[6]);
    // Lowest-numbered winning line supplies the single reported code.
    win_code = CELL_EMPTY;
    for (int i = 7; i >= 0; i--) begin
      if (line_codes[i] != CELL_EMPTY) win_code = line_codes[i];
    end
    full = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (board_q[i] == CELL_EMPTY) full = 1'b0;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    pos_d      = pos_q;
    scan_d     = scan_q;
    jug_d      = jug_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    lleno_d    = lleno_q;
    gan_d      = gan_q;
    gjug_d     = gjug_q;
    last_pos_d = last_pos_q;

    if (clear) begin
      state_d    = StIdle;
      board_d    = {9{CELL_EMPTY}};
      pos_d      = 4'd0;
      scan_d     = 4'd0;
      jug_d      = 1'b0;
      lleno_d    = 1'b0;
      gan_d      = 1'b0;
      gjug_d     = CELL_EMPTY;
      last_pos_d = 4'hF;
    end else begin
      case (state_q)
        StIdle: begin
          // timeout outranks move_req; a timeout on a finished game is
          // swallowed and the coincident move_req is dropped with it.
          if (timeout) begin
            if (!gan_q && !lleno_q) begin
              jug_d   = jug;
              scan_d  = 4'd0;
              state_d = StScan;
            end
          end else if (move_req) begin
            pos_d   = posicion;
            jug_d   = jug;
            state_d = StCheck;
          end
        end
        StCheck: begin
          if ((pos_q > 4'd8) || gan_q || (target_cell != CELL_EMPTY)) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StWrite;
          end
        end
        StScan: begin
          if (scan_cell == CELL_EMPTY) begin
            pos_d   = scan_q;
            state_d = StWrite;
          end else if (scan_q == 4'd8) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            scan_d = scan_q + 4'd1;
          end
        end
        StWrite: begin
          for (int i = 0; i < 9; i++) begin
            if (pos_q == 4'(i)) board_d[i] = mark;
          end
          state_d = StEval;
        end
        StEval: begin
          lleno_d    = full;
          gan_d      = (win_code != CELL_EMPTY);
          gjug_d     = win_code;
          last_pos_d = pos_q;
          ack_d      = 1'b1;
          state_d    = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q    <= StIdle;
      board_q    <= {9{CELL_EMPTY}};
      pos_q      <= 4'd0;
      scan_q     <= 4'd0;
      jug_q      <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      lleno_q    <= 1'b0;
      gan_q      <= 1'b0;
      gjug_q     <= CELL_EMPTY;
      last_pos_q <= 4'hF;
    end else begin
      state_q    <= state_d;
      board_q    <= board_d;
      pos_q      <= pos_d;
      scan_q     <= scan_d;
      jug_q      <= jug_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      lleno_q    <= lleno_d;
      gan_q      <= gan_d;
      gjug_q     <= gjug_d;
      last_pos_q <= last_pos_d;
    end
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        matriz_juego[r][c] = board_q[r * 3 + c];
      end
    end
  end

  assign move_ack    = ack_q;
  assign move_err    = err_q;
  assign busy        = (state_q != StIdle);
  assign lleno       = lleno_q;
  assign ganador     = gan_q;
  assign ganador_jug = gjug_q;
  assign last_pos    = last_pos_q;

endmodule

// File: tb/tb_board_store.sv
// Bench for board_store: a game-level model (board array, line/fullness rules)
// advanced on the cycle each effect must become visible, compared against the
// DUT on every falling edge, plus literal pins after each scenario.
`timescale 1ns / 1ps

module tb_board_store;

  logic                 clk = 1'b0;
  logic                 Reset;
  logic                 clear;
  logic                 move_req;
  logic [3:0]           posicion;
  logic                 jug;
  logic                 timeout;
  logic [2:0][2:0][1:0] matriz_juego;
  logic                 move_ack;
  logic                 move_err;
  logic                 busy;
  logic                 lleno;
  logic                 ganador;
  logic [1:0]           ganador_jug;
  logic [3:0]           last_pos;

  always #10 clk = ~clk;

  board_store dut (
    .clk          (clk),
    .Reset        (Reset),
    .clear        (clear),
    .move_req     (move_req),
    .posicion     (posicion),
    .jug          (jug),
    .timeout      (timeout),
    .matriz_juego (matriz_juego),
    .move_ack     (move_ack),
    .move_err     (move_err),
    .busy         (busy),
    .lleno        (lleno),
    .ganador      (ganador),
    .ganador_jug  (ganador_jug),
    .last_pos     (last_pos)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Expected state of the game as visible in the current cycle.
  logic [1:0] exp_board [9];
  logic       exp_ack, exp_err, exp_busy, exp_lleno, exp_gan;
  logic [1:0] exp_gjug;
  logic [3:0] exp_last;
  bit         chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, want);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          check($sformatf("cell[%0d][%0d] @%0t", r, c, $time), 32'(matriz_juego[r][c]),
                32'(exp_board[r * 3 + c]));
        end
      end
      check($sformatf("move_ack @%0t", $time), 32'(move_ack), 32'(exp_ack));
      check($sformatf("move_err @%0t", $time), 32'(move_err), 32'(exp_err));
      check($sformatf("busy @%0t", $time), 32'(busy), 32'(exp_busy));
      check($sformatf("lleno @%0t", $time), 32'(lleno), 32'(exp_lleno));
      check($sformatf("ganador @%0t", $time), 32'(ganador), 32'(exp_gan));
      check($sformatf("ganador_jug @%0t", $time), 32'(ganador_jug), 32'(exp_gjug));
      check($sformatf("last_pos @%0t", $time), 32'(last_pos), 32'(exp_last));
    end
  end

  function automatic logic [1:0] code_of(input logic j);
    return j ? 2'b10 : 2'b01;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) exp_board[i] = 2'b00;
    exp_ack   = 1'b0;
    exp_err   = 1'b0;
    exp_busy  = 1'b0;
    exp_lleno = 1'b0;
    exp_gan   = 1'b0;
    exp_gjug  = 2'b00;
    exp_last  = 4'hF;
  endtask

  // Game rules: full when no empty cell; a win is any row/column/diagonal of
  // three equal non-empty marks.
  task automatic model_eval();
    int a, b, c;
    exp_lleno = 1'b1;
    for (int i = 0; i < 9; i++) if (exp_board[i] == 2'b00) exp_lleno = 1'b0;
    exp_gan  = 1'b0;
    exp_gjug = 2'b00;
    for (int l = 0; l < 8; l++) begin
      if (l < 3)       begin a = 3 * l; b = a + 1; c = a + 2; end
      else if (l < 6)  begin a = l - 3; b = a + 3; c = a + 6; end
      else if (l == 6) begin a = 0; b = 4; c = 8; end
      else             begin a = 2; b = 4; c = 6; end
      if (exp_board[a] != 2'b00 && exp_board[a] == exp_board[b] &&
          exp_board[b] == exp_board[c]) begin
        exp_gan  = 1'b1;
        exp_gjug = exp_board[a];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in an IDLE cycle t, returns at the start of the cycle after the pulse.
  task automatic do_move(input int pos, input logic j);
    bit invalid;
    invalid = (pos > 8) || exp_gan;
    if (!invalid) invalid = (exp_board[pos] != 2'b00);
    move_req = 1'b1;
    posicion = 4'(pos);
    jug      = j;
    tick();                               // t+1 CHECK
    move_req = 1'b0;
    exp_busy = 1'b1;
    tick();                               // t+2
    if (invalid) begin
      exp_busy = 1'b0;
      exp_err  = 1'b1;
      tick();
      exp_err = 1'b0;
      return;
    end
    tick();                               // t+3 board shows the mark
    exp_board[pos] = code_of(j);
    tick();                               // t+4 ack and flags
    exp_busy = 1'b0;
    exp_ack  = 1'b1;
    exp_last = 4'(pos);
    model_eval();
    tick();
    exp_ack = 1'b0;
  endtask

  task automatic do_timeout(input logic j, input logic with_req, input int req_pos);
    int e;
    timeout  = 1'b1;
    jug      = j;
    move_req = with_req;
    posicion = 4'(req_pos);
    if (exp_gan || exp_lleno) begin
      tick();
      timeout  = 1'b0;
      move_req = 1'b0;
      tick();
      return;
    end
    e = 0;
    while (e < 8 && exp_board[e] != 2'b00) e++;
    tick();                               // t+1 first scan cycle
    timeout  = 1'b0;
    move_req = 1'b0;
    exp_busy = 1'b1;
    repeat (e) tick();                    // remaining scan cycles
    tick();                               // WRITE
    tick();                               // board shows the mark
    exp_board[e] = code_of(j);
    tick();
    exp_busy = 1'b0;
    exp_ack  = 1'b1;
    exp_last = 4'(e);
    model_eval();
    tick();
    exp_ack = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_reset();
  endtask

  logic fill_jug [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    Reset    = 1'b1;
    clear    = 1'b0;
    move_req = 1'b0;
    posicion = 4'd0;
    jug      = 1'b0;
    timeout  = 1'b0;
    model_reset();
    repeat (3) tick();
    check("reset move_ack", 32'(move_ack), 32'd0);
    check("reset move_err", 32'(move_err), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset lleno", 32'(lleno), 32'd0);
    check("reset ganador", 32'(ganador), 32'd0);
    check("reset ganador_jug", 32'(ganador_jug), 32'd0);
    check("reset last_pos", 32'(last_pos), 32'hF);
    check("reset board", 32'(matriz_juego), 32'd0);
    Reset  = 1'b0;
    chk_en = 1;
    tick();

    // Centre move by player 0.
    do_move(4, 1'b0);
    check("lit centre cell", 32'(matriz_juego[1][1]), 32'h1);
    check("lit centre last_pos", 32'(last_pos), 32'd4);
    check("lit centre ganador", 32'(ganador), 32'd0);

    // Occupied cell and out-of-range index are rejected.
    do_move(4, 1'b1);
    do_move(9, 1'b0);
    check("lit reject keeps cell", 32'(matriz_juego[1][1]), 32'h1);
    check("lit reject keeps last_pos", 32'(last_pos), 32'd4);

    // Top row win for player 0.
    do_clear();
    do_move(0, 1'b0);
    do_move(3, 1'b1);
    do_move(1, 1'b0);
    do_move(4, 1'b1);
    do_move(2, 1'b0);
    check("lit win ganador", 32'(ganador), 32'd1);
    check("lit win ganador_jug", 32'(ganador_jug), 32'h1);
    do_move(8, 1'b1);
    do_timeout(1'b1, 1'b0, 0);
    check("lit post-win cell 8", 32'(matriz_juego[2][2]), 32'd0);

    // Timeout skips cells 0 and 1.
    do_clear();
    do_move(0, 1'b0);
    do_move(1, 1'b1);
    do_timeout(1'b1, 1'b0, 0);
    check("lit timeout cell", 32'(matriz_juego[0][2]), 32'h2);
    check("lit timeout last_pos", 32'(last_pos), 32'd2);

    // Full board without a line; timeout and moves then have no effect.
    do_clear();
    for (int i = 0; i < 9; i++) do_move(i, fill_jug[i]);
    check("lit full lleno", 32'(lleno), 32'd1);
    check("lit full ganador", 32'(ganador), 32'd0);
    do_timeout(1'b0, 1'b0, 0);
    check("lit full busy", 32'(busy), 32'd0);
    do_move(4, 1'b0);

    // clear while the mark is being written.
    do_clear();
    move_req = 1'b1;
    posicion = 4'd6;
    jug      = 1'b1;
    tick();
    move_req = 1'b0;
    exp_busy = 1'b1;
    tick();                               // WRITE
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_reset();
    repeat (3) tick();
    check("lit clear-write cell", 32'(matriz_juego[2][0]), 32'd0);
    check("lit clear-write last_pos", 32'(last_pos), 32'hF);

    // move_req and timeout together: timeout path, posicion ignored.
    do_timeout(1'b0, 1'b1, 5);
    check("lit simul cell 0", 32'(matriz_juego[0][0]), 32'h1);
    check("lit simul cell 5", 32'(matriz_juego[1][2]), 32'd0);
    check("lit simul last_pos", 32'(last_pos), 32'd0);

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
